// File: rtl/instr_queue_pkg.sv
// Shared types and defaults for the fetch-to-decode instruction queue.
// Optional feature macro: IFQ_BYPASS_EN (see instr_queue.sv).
package instr_queue_pkg;

   localparam int IFQ_DEPTH_DEFAULT = 4;
   localparam int IFQ_AW            = 30;

   typedef struct packed {
      logic [31:0]       addr;
      logic [31:0]       instr;
      logic [IFQ_AW-1:0] pc_next;
   } ifq_entry_t;

endpackage

// File: rtl/ifq_storage.sv
// Entry array for the instruction queue: one write port, one async read port.
// Data is not reset; occupancy is tracked by the owner.
module ifq_storage
   import instr_queue_pkg::*;
#(
   parameter int DEPTH = IFQ_DEPTH_DEFAULT,
   parameter int PW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [PW-1:0] i_waddr,
   input  ifq_entry_t    i_wdata,
   input  logic [PW-1:0] i_raddr,
   output ifq_entry_t    o_rdata
);

   ifq_entry_t r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instr_queue.sv
// Fetch-to-decode instruction buffer with flush on redirect.
// Define IFQ_BYPASS_EN for zero-latency forwarding when empty.
module instr_queue
   import instr_queue_pkg::*;
#(
   parameter int DEPTH = IFQ_DEPTH_DEFAULT,
   parameter int AW    = IFQ_AW
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [31:0]                in_addr,
   input  logic [31:0]                in_instr,
   input  logic [AW-1:0]              in_pc_next,
   input  logic                       flush,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [31:0]                out_addr,
   output logic [31:0]                out_instr,
   output logic [AW-1:0]              out_pc_next,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_loaded;

   logic       w_bypass;
   logic       w_push;
   logic       w_pop;
   ifq_entry_t w_wdata;
   ifq_entry_t w_rdata;

`ifdef IFQ_BYPASS_EN
   assign w_bypass = (r_count == '0) & in_valid & out_ready & ~flush;
`else
   assign w_bypass = 1'b0;
`endif

   assign in_ready  = (r_count != C_FULL);
   assign out_valid = ((r_count != '0) & ~flush) | w_bypass;
   assign w_push    = in_valid & in_ready & ~flush & ~w_bypass;
   assign w_pop     = out_valid & out_ready & ~w_bypass;
   assign count     = r_count;

   always_comb begin
      w_wdata         = '0;
      w_wdata.addr    = in_addr;
      w_wdata.instr   = in_instr;
      w_wdata.pc_next = IFQ_AW'(in_pc_next);
   end

   ifq_storage #(
      .DEPTH (DEPTH),
      .PW    (PW)
   ) u_storage (
      .clk     (clk),
      .i_we    (w_push),
      .i_waddr (r_wr_ptr),
      .i_wdata (w_wdata),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_rdata)
   );

   // Storage is unreset, so outputs read zero until the first write lands.
   always_comb begin
      out_addr    = '0;
      out_instr   = '0;
      out_pc_next = '0;
      if (w_bypass) begin
         out_addr    = in_addr;
         out_instr   = in_instr;
         out_pc_next = in_pc_next;
      end else if (r_loaded) begin
         out_addr    = w_rdata.addr;
         out_instr   = w_rdata.instr;
         out_pc_next = AW'(w_rdata.pc_next);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_loaded <= 1'b0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
            r_loaded <= 1'b1;
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
         if (w_push & ~w_pop)
            r_count <= r_count + CW'(1);
         else if (w_pop & ~w_push)
            r_count <= r_count - CW'(1);
      end
   end

endmodule

// File: tb/tb_instr_queue.sv
// Scoreboard bench for instr_queue: directed stimulus, decoupled monitor.
// Covers reset, fill, wrap, push+pop, flush and the empty-queue latency path.
module tb_instr_queue;
   import instr_queue_pkg::*;

   localparam int DEPTH = 4;
   localparam int AW    = IFQ_AW;

   typedef struct {
      logic [31:0]   a;
      logic [31:0]   i;
      logic [AW-1:0] p;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   in_addr;
   logic [31:0]   in_instr;
   logic [AW-1:0] in_pc_next;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_addr;
   logic [31:0]   out_instr;
   logic [AW-1:0] out_pc_next;
   logic [2:0]    count;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   instr_queue #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_addr     (in_addr),
      .in_instr    (in_instr),
      .in_pc_next  (in_pc_next),
      .flush       (flush),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_addr    (out_addr),
      .out_instr   (out_instr),
      .out_pc_next (out_pc_next),
      .count       (count)
   );

   function automatic logic [31:0] mk_instr(input logic [31:0] a);
      return {a[23:0], 8'h13};
   endfunction

   function automatic logic [AW-1:0] mk_pcn(input logic [31:0] a);
      return AW'(a >> 2) + AW'(1);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic set(input logic iv, input logic [31:0] a,
                      input logic [31:0] ins, input logic ordy,
                      input logic fl, input logic acc);
      exp_t e;
      in_valid   = iv;
      in_addr    = a;
      in_instr   = ins;
      in_pc_next = mk_pcn(a);
      out_ready  = ordy;
      flush      = fl;
      if (acc) begin
         e.a = a;
         e.i = ins;
         e.p = mk_pcn(a);
         sb.push_back(e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] a);
      set(1'b1, a, mk_instr(a), 1'b0, 1'b0, 1'b1);
      tick();
   endtask

   task automatic drain(input int n);
      for (int k = 0; k < n; k++) begin
         set(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
         tick();
      end
   endtask

   // Monitor: every accepted head is compared against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL mon_unexpected: got addr 0x%08h, expected none",
                        out_addr);
            end else begin
               e = sb.pop_front();
               chk("mon_addr", out_addr, e.a);
               chk("mon_instr", out_instr, e.i);
               chk("mon_pc_next", 32'(out_pc_next), 32'(e.p));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      set(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      #12;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_addr", out_addr, 32'h0);
      rst_n = 1'b1;
      tick();

      // Async reset in the middle of a burst
      push(32'h100);
      push(32'h104);
      push(32'h108);
      chk("burst_count", 32'(count), 32'd3);
      set(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_count", 32'(count), 32'd0);
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      sb.delete();
      #1 rst_n = 1'b1;
      tick();

      // Fill to full, overflow push is ignored, drain in order
      push(32'h0);
      push(32'h4);
      push(32'h8);
      push(32'hC);
      chk("full_count", 32'(count), 32'd4);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      set(1'b1, 32'h10, mk_instr(32'h10), 1'b0, 1'b0, 1'b0);
      tick();
      chk("ovf_count", 32'(count), 32'd4);
      drain(4);
      chk("drained_count", 32'(count), 32'd0);
      chk("drained_out_valid", 32'(out_valid), 32'd0);

      // Steady push+pop across pointer wrap
      push(32'h0);
      for (int i = 1; i <= 10; i++) begin
         set(1'b1, 32'(4 * i), mk_instr(32'(4 * i)), 1'b1, 1'b0, 1'b1);
         tick();
         chk("wrap_count", 32'(count), 32'd1);
      end
      drain(1);
      chk("wrap_end_count", 32'(count), 32'd0);

      // Simultaneous push and pop at count=2
      push(32'h200);
      push(32'h204);
      set(1'b1, 32'h208, mk_instr(32'h208), 1'b1, 1'b0, 1'b1);
      tick();
      chk("pp_count", 32'(count), 32'd2);
      chk("pp_head", out_addr, 32'h204);
      drain(2);
      chk("pp_end_count", 32'(count), 32'd0);

      // Flush with a same-cycle push
      push(32'h300);
      push(32'h304);
      push(32'h308);
      set(1'b1, 32'h40, mk_instr(32'h40), 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      chk("flush_in_ready", 32'(in_ready), 32'd1);
      sb.delete();
      tick();
      set(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("post_flush_count", 32'(count), 32'd0);
      chk("post_flush_out_valid", 32'(out_valid), 32'd0);
      push(32'h80);
      chk("after_flush_head", out_addr, 32'h80);
      drain(1);
      chk("after_flush_count", 32'(count), 32'd0);

      // Empty queue with decode ready
      set(1'b1, 32'hC0, 32'h8C220004, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
`ifdef IFQ_BYPASS_EN
      chk("byp_out_valid", 32'(out_valid), 32'd1);
      chk("byp_out_instr", out_instr, 32'h8C220004);
      chk("byp_count", 32'(count), 32'd0);
      tick();
      set(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      #1;
      chk("byp_after_count", 32'(count), 32'd0);
      chk("byp_after_valid", 32'(out_valid), 32'd0);
`else
      chk("lat_out_valid0", 32'(out_valid), 32'd0);
      tick();
      set(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      chk("lat_out_valid1", 32'(out_valid), 32'd1);
      chk("lat_out_instr", out_instr, 32'h8C220004);
      chk("lat_count", 32'(count), 32'd1);
`endif
      tick();
      drain(2);
      chk("final_count", 32'(count), 32'd0);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
